// File: rtl/tt_puf_pkg.sv
// rtl/tt_puf_pkg.sv - shared types and constants for the PUF sampler
// Contents: controller state encoding, synchroniser depth, vote-counter width helper.
package tt_puf_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RISE  = 3'd1,
      SAMP  = 3'd2,
      FALL  = 3'd3,
      VOTE  = 3'd4,
      VALID = 3'd5
   } state_t;

   localparam int SYNC_STAGES = 2;

   // Wide enough to hold 0..n votes, so the counter can never overflow.
   function automatic int vote_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tt_arbiter_chain.sv
// rtl/tt_arbiter_chain.sv - key-controlled switch chain ending in an arbiter
// Ports:
//   pulse   in  1       launch edge fed into both paths
//   key     in  STAGES  per-stage select: 1 = crossed, 0 = straight
//   arb_out out 1       1 = top path won the race
module tt_arbiter_chain #(
   parameter int STAGES = 12
) (
   input  logic              pulse,
   input  logic [STAGES-1:0] key,
   output logic              arb_out
);

   logic top;
   logic bot;

   // Each mux stage either passes the two paths straight or swaps them.
   // In zero-delay simulation both paths arrive together and the arbiter
   // reads 0; the physical layout supplies the mismatch that decides the race.
   always_comb begin
      top = pulse;
      bot = pulse;
      for (int s = 0; s < STAGES; s++) begin
         if (key[s]) begin
            {top, bot} = {bot, top};
         end
      end
      // Steady-state view of the cross-coupled NAND pair: set when top leads.
      arb_out = top & ~bot;
   end

endmodule

// File: rtl/tt_puf_sampler.sv
// rtl/tt_puf_sampler.sv - multi-chain arbiter PUF sampler with majority voting
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, chal         measurement request and challenge (taken while idle)
//   busy                high whenever the controller is not idle
//   resp_valid/ready    result handshake
//   resp                majority-voted arbiter bit per chain
//   stable              1 = every sample agreed for that chain
module tt_puf_sampler
   import tt_puf_pkg::*;
#(
   parameter int N_CHAINS   = 4,
   parameter int STAGES     = 12,
   parameter int KEY_W      = 4,
   parameter int N_SAMPLES  = 5,
   parameter int SETTLE_CYC = 8,
   parameter int RELAX_CYC  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [KEY_W-1:0]    chal,
   output logic                busy,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [N_CHAINS-1:0] resp,
   output logic [N_CHAINS-1:0] stable
);

   localparam int VW  = vote_w(N_SAMPLES);
   localparam int PW  = $clog2(SETTLE_CYC + RELAX_CYC + 1);
   localparam int SPK = STAGES / KEY_W;
   localparam logic [VW-1:0] HALF      = VW'(N_SAMPLES / 2);
   localparam logic [VW-1:0] ALL       = VW'(N_SAMPLES);
   localparam logic [PW-1:0] RISE_LAST = PW'(SETTLE_CYC - 1);
   localparam logic [PW-1:0] FALL_LAST = PW'(RELAX_CYC - 1);

   if ((N_SAMPLES % 2) == 0 || N_SAMPLES < 1) begin : g_err_samples
      $error("N_SAMPLES must be odd and at least 1");
   end
   if ((STAGES % KEY_W) != 0) begin : g_err_stages
      $error("STAGES must be a multiple of KEY_W");
   end
   if (SETTLE_CYC < 3) begin : g_err_settle
      $error("SETTLE_CYC must be at least 3");
   end
   if (RELAX_CYC < 1) begin : g_err_relax
      $error("RELAX_CYC must be at least 1");
   end

   state_t              state;
   state_t              state_nxt;
   logic [KEY_W-1:0]    chal_q;
   logic [PW-1:0]       phase;
   logic [VW-1:0]       samp_cnt;
   logic [VW-1:0]       votes [N_CHAINS];
   logic [N_CHAINS-1:0] sync_q [SYNC_STAGES];
   logic [N_CHAINS-1:0] arb_raw;
   logic [N_CHAINS-1:0] arb;
   logic [STAGES-1:0]   key;
   logic                pulse;
   logic                samp_last;

   // Each challenge bit steers a run of SPK consecutive stages.
   for (genvar s = 0; s < STAGES; s++) begin : g_key
      assign key[s] = chal_q[s / SPK];
   end

   for (genvar c = 0; c < N_CHAINS; c++) begin : g_chain
      tt_arbiter_chain #(.STAGES(STAGES)) u_chain (
         .pulse   (pulse),
         .key     (key),
         .arb_out (arb_raw[c])
      );
   end

   assign arb       = arb_raw;
   assign samp_last = (samp_cnt + VW'(1)) == ALL;

   // Pulse and status are decoded from state so that the async reset
   // drops them in the same timestep it is asserted.
   always_comb begin
      state_nxt  = state;
      pulse      = 1'b0;
      busy       = 1'b1;
      resp_valid = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = RISE;
         end
         RISE: begin
            pulse = 1'b1;
            if (phase == RISE_LAST) state_nxt = SAMP;
         end
         SAMP: begin
            pulse     = 1'b1;
            state_nxt = FALL;
         end
         FALL: begin
            if (phase == FALL_LAST) state_nxt = samp_last ? VOTE : RISE;
         end
         VOTE: state_nxt = VALID;
         VALID: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         chal_q   <= '0;
         phase    <= '0;
         samp_cnt <= '0;
         resp     <= '0;
         stable   <= '0;
         for (int i = 0; i < N_CHAINS; i++) votes[i] <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start) begin
                  chal_q   <= chal;
                  phase    <= '0;
                  samp_cnt <= '0;
                  for (int i = 0; i < N_CHAINS; i++) votes[i] <= '0;
               end
            end
            RISE: phase <= (phase == RISE_LAST) ? '0 : phase + PW'(1);
            SAMP: begin
               for (int i = 0; i < N_CHAINS; i++) begin
                  votes[i] <= votes[i] + VW'(sync_q[SYNC_STAGES-1][i]);
               end
            end
            FALL: begin
               if (phase == FALL_LAST) begin
                  phase    <= '0;
                  samp_cnt <= samp_cnt + VW'(1);
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            VOTE: begin
               for (int i = 0; i < N_CHAINS; i++) begin
                  resp[i]   <= votes[i] > HALF;
                  stable[i] <= (votes[i] == '0) || (votes[i] == ALL);
               end
            end
            default: ;
         endcase
      end
   end

   // Arbiter outputs can resolve at any time relative to clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= arb;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

endmodule

// File: tb/tb_tt_puf_sampler.sv
// tb/tb_tt_puf_sampler.sv - directed bench for tt_puf_sampler
module tb_tt_puf_sampler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start, resp_ready, busy, resp_valid;
   logic [3:0] chal, resp, stable, arb_drv;
   logic       start8, resp_ready8, busy8, resp_valid8;
   logic [7:0] chal8, resp8, stable8, arb_drv8;

   int n_checks = 0;
   int n_fail = 0;

   tt_puf_sampler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .chal(chal), .busy(busy),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp), .stable(stable)
   );

   tt_puf_sampler #(
      .N_CHAINS(8), .STAGES(16), .KEY_W(8), .N_SAMPLES(3), .SETTLE_CYC(8), .RELAX_CYC(4)
   ) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .chal(chal8), .busy(busy8),
      .resp_valid(resp_valid8), .resp_ready(resp_ready8), .resp(resp8), .stable(stable8)
   );

   // Sample k's arbiter value is applied one edge into its RISE phase (edge 13k+1).
   task automatic run4(input logic [19:0] pats, input logic [3:0] c, input logic [3:0] c_mid,
                       output int lat, output logic busy_ok,
                       output logic [11:0] key_a, output logic [11:0] key_b);
      arb_drv = pats[3:0];
      chal = c;
      key_a = '0;
      key_b = '0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      do begin
         @(posedge clk); #1; lat++;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if ((lat % 13) == 1 && (lat / 13) < 5) arb_drv = pats[4*(lat/13) +: 4];
         if (lat == 10) key_a = dut.key;
         if (lat == 20) chal = c_mid;
         if (lat == 30) key_b = dut.key;
      end while (resp_valid !== 1'b1 && lat < 200);
   endtask

   task automatic run8(input logic [23:0] pats, input logic [7:0] c, output int lat);
      arb_drv8 = pats[7:0];
      chal8 = c;
      @(negedge clk); start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
         if ((lat % 13) == 1 && (lat / 13) < 3) arb_drv8 = pats[8*(lat/13) +: 8];
      end while (resp_valid8 !== 1'b1 && lat < 200);
   endtask

   task automatic handshake4();
      @(negedge clk); resp_ready = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
      n_checks++; if (resp !== 4'h0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", resp); end
      n_checks++; if (stable !== 4'h0) begin n_fail++; $display("FAIL reset_stable: got %h want 0", stable); end
      n_checks++; if (dut.pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b want 0", dut.pulse); end
      n_checks++; if (busy8 !== 1'b0 || resp8 !== 8'h0) begin n_fail++; $display("FAIL reset_dut8: busy %b resp %h want 0/00", busy8, resp8); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_constant();
      int lat; logic bok; logic [11:0] ka, kb;
      run4({5{4'b1010}}, 4'h3, 4'h3, lat, bok, ka, kb);
      n_checks++; if (lat != 66) begin n_fail++; $display("FAIL const_latency: got %0d want 66", lat); end
      n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL const_busy: got %b want 1", bok); end
      n_checks++; if (resp !== 4'b1010) begin n_fail++; $display("FAIL const_resp: got %b want 1010", resp); end
      n_checks++; if (stable !== 4'b1111) begin n_fail++; $display("FAIL const_stable: got %b want 1111", stable); end
   endtask

   task automatic test_hold();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); start = 1'b1; chal = 4'(i);
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid !== 1'b1 || busy !== 1'b1 || resp !== 4'b1010 || stable !== 4'b1111) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: valid %b busy %b resp %b stable %b want 1 1 1010 1111",
                     i, resp_valid, busy, resp, stable);
         end
      end
      @(negedge clk); resp_ready = 1'b1; start = 1'b1;
      @(posedge clk); #1; resp_ready = 1'b0; start = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_exit_busy: got %b want 0", busy); end
      n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL hold_exit_valid: got %b want 0", resp_valid); end
      n_checks++; if (resp !== 4'b1010) begin n_fail++; $display("FAIL hold_resp_kept: got %b want 1010", resp); end
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_start_ignored: busy %b want 0", busy); end
   endtask

   task automatic test_toggle();
      int lat; logic bok; logic [11:0] ka, kb;
      run4({4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0001}, 4'h5, 4'h5, lat, bok, ka, kb);
      n_checks++; if (lat != 66) begin n_fail++; $display("FAIL toggle_latency: got %0d want 66", lat); end
      n_checks++; if (resp !== 4'b0001) begin n_fail++; $display("FAIL toggle_resp: got %b want 0001", resp); end
      n_checks++; if (stable !== 4'b1110) begin n_fail++; $display("FAIL toggle_stable: got %b want 1110", stable); end
      handshake4();
   endtask

   task automatic test_key();
      int lat; logic bok; logic [11:0] ka, kb;
      run4({5{4'b0110}}, 4'b1001, 4'b0110, lat, bok, ka, kb);
      n_checks++; if (ka !== 12'hE07) begin n_fail++; $display("FAIL key_expand: got %h want e07", ka); end
      n_checks++; if (kb !== 12'hE07) begin n_fail++; $display("FAIL key_after_chal_change: got %h want e07", kb); end
      n_checks++; if (resp !== 4'b0110 || stable !== 4'b1111) begin n_fail++; $display("FAIL key_result: resp %b stable %b want 0110 1111", resp, stable); end
      handshake4();
   endtask

   task automatic test_reset_mid();
      int lat; logic bok; logic [11:0] ka, kb;
      arb_drv = 4'hF;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      repeat (28) @(posedge clk);
      #1;
      n_checks++; if (dut.pulse !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL midrun_pre: pulse %b busy %b want 1 1", dut.pulse, busy); end
      #1; rst_n = 1'b0;
      #1;
      n_checks++; if (dut.pulse !== 1'b0) begin n_fail++; $display("FAIL midrun_pulse: got %b want 0", dut.pulse); end
      n_checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_status: busy %b valid %b want 0 0", busy, resp_valid); end
      n_checks++; if (resp !== 4'h0 || stable !== 4'h0) begin n_fail++; $display("FAIL midrun_outputs: resp %b stable %b want 0000 0000", resp, stable); end
      @(negedge clk); rst_n = 1'b1;
      run4({5{4'hF}}, 4'h7, 4'h7, lat, bok, ka, kb);
      n_checks++; if (lat != 66) begin n_fail++; $display("FAIL rerun_latency: got %0d want 66", lat); end
      n_checks++; if (resp !== 4'hF || stable !== 4'hF) begin n_fail++; $display("FAIL rerun_result: resp %b stable %b want 1111 1111", resp, stable); end
      handshake4();
   endtask

   task automatic test_param();
      int lat;
      run8({8'hAA, 8'hCC, 8'hF0}, 8'h5A, lat);
      n_checks++; if (lat != 40) begin n_fail++; $display("FAIL p8_latency: got %0d want 40", lat); end
      n_checks++; if (resp8 !== 8'hE8) begin n_fail++; $display("FAIL p8_resp: got %h want e8", resp8); end
      n_checks++; if (stable8 !== 8'h81) begin n_fail++; $display("FAIL p8_stable: got %h want 81", stable8); end
      @(negedge clk); resp_ready8 = 1'b1;
      @(posedge clk); #1; resp_ready8 = 1'b0;
      n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL p8_exit: busy %b want 0", busy8); end
   endtask

   initial begin
      start = 1'b0; resp_ready = 1'b0; chal = '0; arb_drv = '0;
      start8 = 1'b0; resp_ready8 = 1'b0; chal8 = '0; arb_drv8 = '0;
      force dut.arb = arb_drv;
      force dut8.arb = arb_drv8;
      test_reset();
      test_constant();
      test_hold();
      test_toggle();
      test_key();
      test_reset_mid();
      test_param();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
